lsu_queue: RTL and testbench

//  Parametrised load/store unit: next generation of the core's single-request DMEM_IDLE/REQ_SENT/REQ_ACKED stage.

---
 rtl/lsu_queue_pkg.sv | 88 ++++++++
 rtl/lsu_queue_if.sv | 28 ++
 rtl/lsu_tag_fifo.sv | 68 ++++++
 rtl/lsu_queue.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_queue.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_queue_pkg.sv
// -----------------------------------------------------------------------------
// lsu_queue_pkg
// Shared definitions for the load/store queue:
//   lsu_size_e   - access size encoding (BYTE/HALF/WORD, 3 is illegal)
//   lsu_track_s  - per-request record kept while a memory access is in flight
//   lsu_req_s    - holding-register contents for a request awaiting issue
//   lsu_be / lsu_wdata / lsu_extract / lsu_misaligned - lane helpers
// Tags are carried at LSU_TAG_W_MAX bits internally; the top narrows them
// back to TAG_WIDTH_P (so TAG_WIDTH_P must not exceed LSU_TAG_W_MAX).
// -----------------------------------------------------------------------------
package lsu_queue_pkg;

    localparam int LSU_TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2,
        LSU_ILL  = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic [LSU_TAG_W_MAX-1:0] tag;
        logic                     wen;
        lsu_size_e                size;
        logic                     is_unsigned;
        logic [1:0]               offset;
    } lsu_track_s;

    typedef struct packed {
        logic [LSU_TAG_W_MAX-1:0] tag;
        logic                     wen;
        lsu_size_e                size;
        logic                     is_unsigned;
        logic [31:0]              addr;
        logic [31:0]              wdata;
    } lsu_req_s;

    // Byte enables for an access; the offset is truncated to the access size.
    function automatic logic [3:0] lsu_be(input lsu_size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LSU_BYTE: be = 4'b0001 << off;
            LSU_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the size could land in.
    function automatic logic [31:0] lsu_wdata(input lsu_size_e size, input logic [31:0] wdata);
        logic [31:0] res;
        case (size)
            LSU_BYTE: res = {4{wdata[7:0]}};
            LSU_HALF: res = {2{wdata[15:0]}};
            default:  res = wdata;
        endcase
        return res;
    endfunction

    // Select the addressed lane of a memory word and sign/zero extend it.
    function automatic logic [31:0] lsu_extract(input logic [31:0] rdata, input lsu_size_e size,
                                                input logic is_unsigned, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LSU_BYTE: res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            LSU_HALF: res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default:  res = rdata;
        endcase
        return res;
    endfunction

    // True when the address is not naturally aligned for the size.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
        logic mis;
        case (size)
            LSU_BYTE: mis = 1'b0;
            LSU_HALF: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_queue_if.sv
// -----------------------------------------------------------------------------
// lsu_queue_if
// Data-memory bus between the LSU (master) and data memory (slave).
//   request : mem_valid_o / mem_yumi_i, mem_wen_o, mem_addr_o, mem_wdata_o, mem_be_o
//   response: mem_resp_valid_i / mem_resp_yumi_o, mem_rdata_i (in request order)
// Suffixes give the direction as seen from the LSU.
// -----------------------------------------------------------------------------
interface lsu_queue_if;
    logic        mem_valid_o;
    logic        mem_yumi_i;
    logic        mem_wen_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_yumi_o;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_resp_yumi_o,
        input  mem_yumi_i, mem_resp_valid_i, mem_rdata_i
    );

    modport slave (
        input  mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_resp_yumi_o,
        output mem_yumi_i, mem_resp_valid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_tag_fifo.sv
// -----------------------------------------------------------------------------
// lsu_tag_fifo
// DEPTH_P-entry synchronous FIFO of lsu_track_s records, one per request in
// flight to memory. A push while full is taken only if a pop happens in the
// same cycle. Pushes while full without a pop and pops while empty are ignored.
// Ports: clk, reset (sync, active-high), i_push/i_din, i_pop/o_dout,
//        o_full, o_empty, o_count (occupancy, 0..DEPTH_P).
// -----------------------------------------------------------------------------
module lsu_tag_fifo
    import lsu_queue_pkg::*;
#(
    parameter int DEPTH_P = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  lsu_track_s                 i_din,
    input  logic                       i_pop,
    output lsu_track_s                 o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH_P):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = $clog2(DEPTH_P) + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    lsu_track_s       r_mem [DEPTH_P];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH_P));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Entry storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH_P is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/lsu_queue.sv
// -----------------------------------------------------------------------------
// lsu_queue
// Load/store unit with up to DEPTH_P requests outstanding to data memory and
// in-order retirement. Handles byte/half/word sizing, store lane replication
// and byte enables, and load lane selection with sign/zero extension.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_*                 core request channel (valid/ready)
//   resp_*                core response channel (valid/yumi)
//   mem                   data-memory bus (lsu_queue_if.master)
//   outstanding_o         requests issued to memory and not yet answered
//   err_o                 sticky: response with empty tracker, or size 3
//   misalign_o            only with LSU_MISALIGN_EXC_EN defined
// Build option LSU_MISALIGN_EXC_EN: misaligned requests are never sent to
// memory; once everything older has retired they retire with rdata=0 and
// misalign_o=1. Without it, misaligned addresses are truncated.
// -----------------------------------------------------------------------------
module lsu_queue
    import lsu_queue_pkg::*;
#(
    parameter int DEPTH_P     = 4,
    parameter int TAG_WIDTH_P = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_wen_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [TAG_WIDTH_P-1:0]   req_tag_i,
    output logic                     resp_valid_o,
    input  logic                     resp_yumi_i,
    output logic [31:0]              resp_rdata_o,
    output logic [TAG_WIDTH_P-1:0]   resp_tag_o,
    output logic                     resp_wen_o,
    lsu_queue_if.master              mem,
    output logic [$clog2(DEPTH_P):0] outstanding_o,
    output logic                     err_o
`ifdef LSU_MISALIGN_EXC_EN
    ,
    output logic                     misalign_o
`endif
);
    localparam int CNT_W = $clog2(DEPTH_P) + 1;

    lsu_req_s               r_hold;
    logic                   r_hold_valid;
    logic                   r_resp_valid;
    logic [31:0]            r_resp_rdata;
    logic [TAG_WIDTH_P-1:0] r_resp_tag;
    logic                   r_resp_wen;
    logic                   r_err;

    lsu_req_s               w_req;
    lsu_size_e              w_size_norm;
    lsu_track_s             w_track_in;
    lsu_track_s             w_track_out;
    logic                   w_req_fire;
    logic                   w_hold_mis;
    logic                   w_issue;
    logic                   w_mis_retire;
    logic                   w_resp_free;
    logic                   w_mem_resp_yumi;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;

    // Acceptance depends only on registered state, never on mem_yumi_i.
    assign req_ready_o = !r_hold_valid && (w_count != CNT_W'(DEPTH_P));
    assign w_req_fire  = req_valid_i && req_ready_o;

    // Illegal size 3 is carried as WORD from here on.
    assign w_size_norm       = (req_size_i == 2'd3) ? LSU_WORD : lsu_size_e'(req_size_i);
    assign w_req.tag         = LSU_TAG_W_MAX'(req_tag_i);
    assign w_req.wen         = req_wen_i;
    assign w_req.size        = w_size_norm;
    assign w_req.is_unsigned = req_unsigned_i;
    assign w_req.addr        = req_addr_i;
    assign w_req.wdata       = lsu_wdata(w_size_norm, req_wdata_i);

`ifdef LSU_MISALIGN_EXC_EN
    assign w_hold_mis = lsu_misaligned(r_hold.size, r_hold.addr[1:0]);
    // Retire a misaligned request only once everything older has drained, so order holds.
    assign w_mis_retire = r_hold_valid && w_hold_mis && w_empty
                          && !mem.mem_resp_valid_i && w_resp_free;
`else
    assign w_hold_mis   = 1'b0;
    assign w_mis_retire = 1'b0;
`endif

    assign w_issue = r_hold_valid && !w_hold_mis && mem.mem_yumi_i;

    // Memory request comes straight from the holding register, so it is stable until yumi.
    assign mem.mem_valid_o = r_hold_valid && !w_hold_mis;
    assign mem.mem_wen_o   = r_hold.wen;
    assign mem.mem_addr_o  = {r_hold.addr[31:2], 2'b00};
    assign mem.mem_wdata_o = r_hold.wdata;
    assign mem.mem_be_o    = lsu_be(r_hold.size, r_hold.addr[1:0]);

    assign w_track_in.tag         = r_hold.tag;
    assign w_track_in.wen         = r_hold.wen;
    assign w_track_in.size        = r_hold.size;
    assign w_track_in.is_unsigned = r_hold.is_unsigned;
    assign w_track_in.offset      = r_hold.addr[1:0];

    // A memory response is taken whenever the response register is free or draining.
    assign w_resp_free         = !r_resp_valid || resp_yumi_i;
    assign w_mem_resp_yumi     = mem.mem_resp_valid_i && w_resp_free;
    assign mem.mem_resp_yumi_o = w_mem_resp_yumi;
    assign w_pop               = w_mem_resp_yumi && !w_empty;
    assign w_drop              = w_mem_resp_yumi && w_empty;

    lsu_tag_fifo #(
        .DEPTH_P (DEPTH_P)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_issue),
        .i_din   (w_track_in),
        .i_pop   (w_pop),
        .o_dout  (w_track_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Holding register: one accepted request waiting for the memory to take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_req_fire) begin
            r_hold_valid <= 1'b1;
            r_hold       <= w_req;
        end else if (w_issue || w_mis_retire) begin
            r_hold_valid <= 1'b0;
        end else begin
            r_hold_valid <= r_hold_valid;
        end
    end

    // Response register: loaded on retire, cleared when the core consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_tag   <= {TAG_WIDTH_P{1'b0}};
            r_resp_wen   <= 1'b0;
        end else if (w_pop) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_track_out.wen ? 32'd0
                          : lsu_extract(mem.mem_rdata_i, w_track_out.size,
                                        w_track_out.is_unsigned, w_track_out.offset);
            r_resp_tag   <= TAG_WIDTH_P'(w_track_out.tag);
            r_resp_wen   <= w_track_out.wen;
        end else if (w_mis_retire) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_resp_tag   <= TAG_WIDTH_P'(r_hold.tag);
            r_resp_wen   <= r_hold.wen;
        end else if (resp_yumi_i) begin
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= r_resp_valid;
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic r_resp_mis;

    // Flags a response produced by the misalignment path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_mis <= 1'b0;
        end else if (w_pop) begin
            r_resp_mis <= 1'b0;
        end else if (w_mis_retire) begin
            r_resp_mis <= 1'b1;
        end else begin
            r_resp_mis <= r_resp_mis;
        end
    end

    assign misalign_o = r_resp_valid && r_resp_mis;
`endif

    // Sticky error: orphan memory response or illegal size accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_drop || (w_req_fire && (req_size_i == 2'd3))) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign resp_rdata_o  = r_resp_rdata;
    assign resp_tag_o    = r_resp_tag;
    assign resp_wen_o    = r_resp_wen;
    assign outstanding_o = w_count;
    assign err_o         = r_err;
endmodule

// File: tb/tb_lsu_queue.sv
module tb_lsu_queue;
    import lsu_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAGW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready_o;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [TAGW-1:0] req_tag;
    logic            resp_valid_o;
    logic            resp_yumi;
    logic [31:0]     resp_rdata_o;
    logic [TAGW-1:0] resp_tag_o;
    logic            resp_wen_o;
    logic [2:0]      outstanding_o;
    logic            err_o;

    lsu_queue_if mem_if ();

    lsu_queue #(.DEPTH_P(DEPTH), .TAG_WIDTH_P(TAGW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_wen_i      (req_wen),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_tag_i      (req_tag),
        .resp_valid_o   (resp_valid_o),
        .resp_yumi_i    (resp_yumi),
        .resp_rdata_o   (resp_rdata_o),
        .resp_tag_o     (resp_tag_o),
        .resp_wen_o     (resp_wen_o),
        .mem            (mem_if),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic            wen;
        logic [31:0]     rdata;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [TAGW-1:0] tag, input logic wen, input logic [31:0] rdata);
        exp_t e;
        e.tag   = tag;
        e.wen   = wen;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [TAGW-1:0] tag);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tag;
        for (int k = 0; k < 20; k++) begin
            if (req_ready_o) break;
            tick();
        end
        chk("req_ready_wait", {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_mem_valid();
        for (int k = 0; k < 20; k++) begin
            if (mem_if.mem_valid_o) break;
            tick();
        end
        chk("mem_valid_wait", {31'd0, mem_if.mem_valid_o}, 32'd1);
    endtask

    task automatic mem_accept();
        wait_mem_valid();
        mem_if.mem_yumi_i = 1'b1;
        tick();
        mem_if.mem_yumi_i = 1'b0;
    endtask

    task automatic mem_respond(input logic [31:0] rdata);
        mem_if.mem_resp_valid_i = 1'b1;
        mem_if.mem_rdata_i      = rdata;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (mem_if.mem_resp_yumi_o) break;
            tick();
        end
        chk("mem_resp_yumi_wait", {31'd0, mem_if.mem_resp_yumi_o}, 32'd1);
        tick();
        mem_if.mem_resp_valid_i = 1'b0;
    endtask

    // Compare the presented response against the scoreboard head without consuming it.
    task automatic check_resp();
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid_o) break;
            tick();
        end
        chk("resp_valid_wait", {31'd0, resp_valid_o}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata_o, e.rdata);
            chk("resp_tag", {27'd0, resp_tag_o}, {27'd0, e.tag});
            chk("resp_wen", {31'd0, resp_wen_o}, {31'd0, e.wen});
        end
    endtask

    task automatic collect();
        check_resp();
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
    endtask

    initial begin
        // wen size uns addr wdata mem_rdata | exp addr be wdata rdata
        vecs[0] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80};
        vecs[1] = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 32'h100, 4'b1000, 32'h0, 32'h0000_0080};
        vecs[2] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD_1234, 32'hFFFF_FFFF, 32'h200, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[3] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 32'h8001_7FFF, 32'h4, 4'b1100, 32'h0, 32'hFFFF_8001};
        vecs[5] = '{1'b0, 2'd1, 1'b1, 32'h4, 32'h0, 32'h8001_F00D, 32'h4, 4'b0011, 32'h0, 32'h0000_F00D};
        vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h5A, 32'hFFFF_FFFF, 32'h20, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        vecs[7] = '{1'b1, 2'd2, 1'b0, 32'h33, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h30, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[8] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h1122_3344, 32'h40, 4'b1111, 32'h0, 32'h1122_3344};

        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0; resp_yumi = 1'b0;
        mem_if.mem_yumi_i = 1'b0; mem_if.mem_resp_valid_i = 1'b0; mem_if.mem_rdata_i = 32'd0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_if.mem_valid_o}, 32'd0);
        chk("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);

        // Table: one request at a time, response one cycle after yumi
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, TAGW'(i));
            sb_push(TAGW'(i), vecs[i].wen, vecs[i].e_rdata);
            wait_mem_valid();
            chk("vec_mem_addr", mem_if.mem_addr_o, vecs[i].e_addr);
            chk("vec_mem_be", {28'd0, mem_if.mem_be_o}, {28'd0, vecs[i].e_be});
            chk("vec_mem_wdata", mem_if.mem_wdata_o, vecs[i].e_wdata);
            chk("vec_mem_wen", {31'd0, mem_if.mem_wen_o}, {31'd0, vecs[i].wen});
            mem_if.mem_yumi_i = 1'b1;
            tick();
            mem_if.mem_yumi_i = 1'b0;
            chk("vec_outstanding", {29'd0, outstanding_o}, 32'd1);
            mem_if.mem_resp_valid_i = 1'b1;
            mem_if.mem_rdata_i      = vecs[i].mrdata;
            #1;
            chk("vec_retire_yumi", {31'd0, mem_if.mem_resp_yumi_o}, 32'd1);
            tick();
            mem_if.mem_resp_valid_i = 1'b0;
            chk("vec_resp_latency", {31'd0, resp_valid_o}, 32'd1);
            collect();
            chk("vec_err", {31'd0, err_o}, (i == 8) ? 32'd1 : 32'd0);
        end

        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_err", {31'd0, err_o}, 32'd0);

        // Memory stalls 5 cycles: request fields stable, core blocked meanwhile
        issue(1'b1, 2'd1, 1'b0, 32'h86, 32'h0000_BEEF, 5'd7);
        sb_push(5'd7, 1'b1, 32'h0);
        wait_mem_valid();
        req_valid = 1'b1; req_addr = 32'h999; req_tag = 5'd9;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", {31'd0, mem_if.mem_valid_o}, 32'd1);
            chk("stall_addr", mem_if.mem_addr_o, 32'h84);
            chk("stall_be", {28'd0, mem_if.mem_be_o}, 32'hC);
            chk("stall_wdata", mem_if.mem_wdata_o, 32'hBEEF_BEEF);
            chk("stall_ready", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        req_valid = 1'b0;
        mem_accept();
        mem_respond(32'h1357_9BDF);
        collect();

        // Fill the tracker with no responses
        for (int t = 0; t < 4; t++) begin
            issue(1'b0, 2'd2, 1'b0, 32'h100 + 32'(t * 4), 32'h0, TAGW'(10 + t));
            sb_push(TAGW'(10 + t), 1'b0, 32'hA000_0000 + 32'(t));
            mem_accept();
        end
        chk("full_outstanding", {29'd0, outstanding_o}, 32'd4);
        chk("full_ready", {31'd0, req_ready_o}, 32'd0);
        chk("full_err", {31'd0, err_o}, 32'd0);
        mem_respond(32'hA000_0000);
        collect();
        chk("after_retire_outstanding", {29'd0, outstanding_o}, 32'd3);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd14);
        sb_push(5'd14, 1'b0, 32'hA000_0004);
        wait_mem_valid();
        // Issue and retire in the same cycle
        mem_if.mem_yumi_i = 1'b1;
        mem_if.mem_resp_valid_i = 1'b1;
        mem_if.mem_rdata_i = 32'hA000_0001;
        #1;
        chk("same_cycle_resp_yumi", {31'd0, mem_if.mem_resp_yumi_o}, 32'd1);
        tick();
        mem_if.mem_yumi_i = 1'b0;
        mem_if.mem_resp_valid_i = 1'b0;
        chk("same_cycle_outstanding", {29'd0, outstanding_o}, 32'd3);
        collect();
        mem_respond(32'hA000_0002); collect();
        mem_respond(32'hA000_0003); collect();
        mem_respond(32'hA000_0004); collect();
        chk("drained_outstanding", {29'd0, outstanding_o}, 32'd0);

        // Core back-pressure holds off memory responses
        for (int t = 1; t <= 3; t++) begin
            issue(1'b0, 2'd2, 1'b0, 32'h300 + 32'(t * 4), 32'h0, TAGW'(t));
            sb_push(TAGW'(t), 1'b0, 32'h0000_00D0 + 32'(t));
            mem_accept();
        end
        mem_respond(32'h0000_00D1);
        mem_if.mem_resp_valid_i = 1'b1;
        mem_if.mem_rdata_i = 32'h0000_00D2;
        #1;
        chk("bp_resp_yumi0", {31'd0, mem_if.mem_resp_yumi_o}, 32'd0);
        tick();
        chk("bp_resp_yumi1", {31'd0, mem_if.mem_resp_yumi_o}, 32'd0);
        chk("bp_tag_held", {27'd0, resp_tag_o}, 32'd1);
        check_resp();
        resp_yumi = 1'b1;
        #1;
        chk("bp_release_yumi", {31'd0, mem_if.mem_resp_yumi_o}, 32'd1);
        tick();
        resp_yumi = 1'b0;
        mem_if.mem_resp_valid_i = 1'b0;
        collect();
        mem_respond(32'h0000_00D3);
        collect();
        chk("sb_drained", sb_q.size(), 32'd0);

        // Orphan response with empty tracker
        chk("orphan_outstanding", {29'd0, outstanding_o}, 32'd0);
        mem_if.mem_resp_valid_i = 1'b1;
        mem_if.mem_rdata_i = 32'hFFFF_0000;
        #1;
        chk("orphan_yumi", {31'd0, mem_if.mem_resp_yumi_o}, 32'd1);
        tick();
        mem_if.mem_resp_valid_i = 1'b0;
        chk("orphan_no_resp", {31'd0, resp_valid_o}, 32'd0);
        chk("orphan_err", {31'd0, err_o}, 32'd1);
        tick(); tick(); tick();
        chk("orphan_err_sticky", {31'd0, err_o}, 32'd1);

        // Reset mid-flight
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd20); mem_accept();
        issue(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 5'd21); mem_accept();
        issue(1'b0, 2'd2, 1'b0, 32'h408, 32'h0, 5'd22);
        chk("mid_outstanding", {29'd0, outstanding_o}, 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_outstanding", {29'd0, outstanding_o}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("midrst_mem_valid", {31'd0, mem_if.mem_valid_o}, 32'd0);
        chk("midrst_err", {31'd0, err_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
